fmap_streamer: RTL and testbench



---
 rtl/fmap_streamer_pkg.sv | 28 ++
 rtl/fmap_streamer_if.sv | 39 +++
 rtl/fmap_streamer_raster_counter.sv | 48 ++++
 rtl/fmap_streamer.sv | 120 ++++++++++++
 tb/tb_fmap_streamer.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/fmap_streamer_pkg.sv
// Shared helpers and types for the feature-map streamer: clog2 utility,
// FSM state encoding and the packed pixel type.
package functions_pkg;
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction
endpackage

package stream_pkg;
  localparam int PIX_CH_NUM     = 4;
  localparam int PIX_DOUT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fmap_stream_state_t;

  typedef logic [PIX_CH_NUM-1:0][PIX_DOUT_WIDTH-1:0] pixel_t;
endpackage

// File: rtl/fmap_streamer_if.sv
// Control, RAM-read and pixel-stream signals of the feature-map streamer.
// master = streamer side, slave = controller/RAM/consumer side.
interface fmap_streamer_if
  import functions_pkg::*;
#(
  parameter int FRAME_H_MAX = 224,
  parameter int FRAME_W_MAX = 224,
  parameter int DOUT_WIDTH  = 8,
  parameter int CH_NUM      = 4,
  parameter int ADDR_WIDTH  = clog2(FRAME_H_MAX*FRAME_W_MAX)
);
  localparam int HW = clog2(FRAME_H_MAX) + 1;
  localparam int WW = clog2(FRAME_W_MAX) + 1;

  logic [HW-1:0]                        frame_h;
  logic [WW-1:0]                        frame_w;
  logic [ADDR_WIDTH-1:0]                base_addr;
  logic                                 start;
  logic                                 hold;
  logic                                 busy;
  logic                                 done;
  logic                                 rd_en;
  logic [ADDR_WIDTH-1:0]                rd_addr;
  logic [CH_NUM-1:0][DOUT_WIDTH-1:0]    rd_data;
  logic                                 frame_start;
  logic                                 frame_end;
  logic                                 dout_vld;
  logic [CH_NUM-1:0][DOUT_WIDTH-1:0]    dout;

  modport master (
    input  frame_h, frame_w, base_addr, start, hold, rd_data,
    output busy, done, rd_en, rd_addr, frame_start, frame_end, dout_vld, dout
  );

  modport slave (
    output frame_h, frame_w, base_addr, start, hold, rd_data,
    input  busy, done, rd_en, rd_addr, frame_start, frame_end, dout_vld, dout
  );
endinterface

// File: rtl/fmap_streamer_raster_counter.sv
// Row/column raster counter with clear and enable; flags the first and
// last position of an h x w frame.
module raster_counter #(
  parameter int HW = 9,
  parameter int WW = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  input  logic [HW-1:0] h,
  input  logic [WW-1:0] w,
  output logic [HW-1:0] row,
  output logic [WW-1:0] col,
  output logic          first,
  output logic          last
);
  logic [HW-1:0] row_reg;
  logic [WW-1:0] col_reg;
  logic          col_end;
  logic          row_end;

  assign col_end = (col_reg == w - WW'(1));
  assign row_end = (row_reg == h - HW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_reg <= '0;
      col_reg <= '0;
    end else if (clr) begin
      row_reg <= '0;
      col_reg <= '0;
    end else if (en) begin
      if (col_end) begin
        col_reg <= '0;
        // Wrap the row too, so the counter is ready for the next frame
        row_reg <= row_end ? '0 : row_reg + HW'(1);
      end else begin
        col_reg <= col_reg + WW'(1);
      end
    end
  end

  assign row   = row_reg;
  assign col   = col_reg;
  assign first = (row_reg == '0) && (col_reg == '0);
  assign last  = row_end && col_end;
endmodule

// File: rtl/fmap_streamer.sv
// Replays a stored feature map from a 1-cycle-latency RAM as a raster
// pixel stream with frame_start/frame_end markers.
module fmap_streamer
  import functions_pkg::*;
  import stream_pkg::*;
#(
  parameter int FRAME_H_MAX = 224,
  parameter int FRAME_W_MAX = 224,
  parameter int DOUT_WIDTH  = 8,
  parameter int CH_NUM      = 4,
  parameter int ADDR_WIDTH  = clog2(FRAME_H_MAX*FRAME_W_MAX)
) (
  input  logic            clk,
  input  logic            reset,
  fmap_streamer_if.master bus
);
  localparam int HW = clog2(FRAME_H_MAX) + 1;
  localparam int WW = clog2(FRAME_W_MAX) + 1;
  localparam logic [HW-1:0] H_MAX_V = HW'(FRAME_H_MAX);
  localparam logic [WW-1:0] W_MAX_V = WW'(FRAME_W_MAX);

  fmap_stream_state_t state_reg, state_next;

  logic [HW-1:0]                     h_reg;
  logic [WW-1:0]                     w_reg;
  logic [ADDR_WIDTH-1:0]             addr_reg;
  logic                              done_reg;
  logic                              dout_vld_reg;
  logic                              frame_start_reg;
  logic                              frame_end_reg;
  logic [CH_NUM-1:0][DOUT_WIDTH-1:0] dout_hold_reg;

  logic accept;
  logic zero_dim;
  logic issue;
  logic pix_first;
  logic pix_last;
  logic [HW-1:0] row_unused;
  logic [WW-1:0] col_unused;

  assign accept   = (state_reg == IDLE) && bus.start;
  assign zero_dim = (bus.frame_h == '0) || (bus.frame_w == '0);
  assign issue    = (state_reg == RUN) && !bus.hold;

  raster_counter #(.HW(HW), .WW(WW)) u_raster (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .en    (issue),
    .h     (h_reg),
    .w     (w_reg),
    .row   (row_unused),
    .col   (col_unused),
    .first (pix_first),
    .last  (pix_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept && !zero_dim) state_next = RUN;
      RUN:     if (issue && pix_last)   state_next = DRAIN;
      DRAIN:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.rd_en = 1'b0;
    bus.busy  = 1'b0;
    case (state_reg)
      RUN: begin
        bus.rd_en = issue;
        bus.busy  = 1'b1;
      end
      DRAIN:   bus.busy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_reg           <= '0;
      w_reg           <= '0;
      addr_reg        <= '0;
      done_reg        <= 1'b0;
      dout_vld_reg    <= 1'b0;
      frame_start_reg <= 1'b0;
      frame_end_reg   <= 1'b0;
      dout_hold_reg   <= '0;
    end else begin
      if (accept) begin
        h_reg    <= (bus.frame_h > H_MAX_V) ? H_MAX_V : bus.frame_h;
        w_reg    <= (bus.frame_w > W_MAX_V) ? W_MAX_V : bus.frame_w;
        addr_reg <= bus.base_addr;
      end else if (issue) begin
        // Address wraps modulo 2^ADDR_WIDTH by construction
        addr_reg <= addr_reg + ADDR_WIDTH'(1);
      end
      done_reg        <= (accept && zero_dim) || (state_reg == DRAIN);
      dout_vld_reg    <= issue;
      frame_start_reg <= issue && pix_first;
      frame_end_reg   <= issue && pix_last;
      if (dout_vld_reg) dout_hold_reg <= bus.rd_data;
    end
  end

  assign bus.rd_addr     = addr_reg;
  assign bus.done        = done_reg;
  assign bus.dout_vld    = dout_vld_reg;
  assign bus.frame_start = frame_start_reg;
  assign bus.frame_end   = frame_end_reg;
  // Pass RAM data straight through on valid beats, otherwise show the last beat
  assign bus.dout        = dout_vld_reg ? bus.rd_data : dout_hold_reg;
endmodule

// File: tb/tb_fmap_streamer.sv
// Self-checking bench: table-driven frames, random frames with random holds,
// and a mid-frame reset sequence, all against a raster-order reference model.
module tb_fmap_streamer;
  import stream_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fmap_streamer_if #(.FRAME_H_MAX(224), .FRAME_W_MAX(224), .DOUT_WIDTH(8),
                     .CH_NUM(4), .ADDR_WIDTH(16)) bus ();

  fmap_streamer #(.FRAME_H_MAX(224), .FRAME_W_MAX(224), .DOUT_WIDTH(8),
                  .CH_NUM(4), .ADDR_WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic pixel_t pix_of(input logic [15:0] a);
    return {a, a ^ 16'h5AC3};
  endfunction

  // RAM model: registered read, content is a function of the address
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= pix_of(bus.rd_addr);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"},        64'(bus.busy), 64'(0));
    chk({tag, "_done"},        64'(bus.done), 64'(0));
    chk({tag, "_rd_en"},       64'(bus.rd_en), 64'(0));
    chk({tag, "_rd_addr"},     64'(bus.rd_addr), 64'(0));
    chk({tag, "_frame_start"}, 64'(bus.frame_start), 64'(0));
    chk({tag, "_frame_end"},   64'(bus.frame_end), 64'(0));
    chk({tag, "_dout_vld"},    64'(bus.dout_vld), 64'(0));
    chk({tag, "_dout"},        64'(bus.dout), 64'(0));
  endtask

  // Must be called between a negedge and the following posedge.
  // mode: 0 no hold, 1 random hold, 2 hold for 2 cycles after the 5th issue.
  task automatic run_frame(input int h, input int w, input logic [15:0] base,
                           input int mode, input int start_k,
                           input int exp_n, input int exp_done_k);
    logic [15:0] q[$];
    int hc, wc, n, iss, beat, last_k, held, done_k;
    logic hold, exp_rd, prev_rd, exp_done, finished;
    hc = (h > 224) ? 224 : h;
    wc = (w > 224) ? 224 : w;
    for (int r = 0; r < hc; r++)
      for (int c = 0; c < wc; c++)
        q.push_back(16'(int'(base) + r * wc + c));
    n = q.size();
    bus.frame_h   = 9'(h);
    bus.frame_w   = 9'(w);
    bus.base_addr = base;
    bus.start     = 1'b1;
    bus.hold      = 1'b0;
    @(posedge clk);
    iss = 0; beat = 0; last_k = -1; held = 0; done_k = -1;
    prev_rd = 1'b0; finished = 1'b0;
    for (int k = 1; k < 3000 && !finished; k++) begin
      @(negedge clk);
      bus.start = (k == start_k);
      if (mode == 1)      hold = ($urandom_range(0, 3) == 0);
      else if (mode == 2) hold = (iss == 5) && (held < 2);
      else                hold = 1'b0;
      if (mode == 2 && hold) held++;
      bus.hold = hold;
      #1;
      exp_rd = !hold && (iss < n);
      chk("rd_en", 64'(bus.rd_en), 64'(exp_rd));
      if (exp_rd) begin
        chk("rd_addr", 64'(bus.rd_addr), 64'(q[iss]));
        iss++;
        if (iss == n) last_k = k;
      end
      chk("dout_vld", 64'(bus.dout_vld), 64'(prev_rd));
      if (prev_rd) begin
        chk("dout", 64'(bus.dout), 64'(pix_of(q[beat])));
        chk("frame_start", 64'(bus.frame_start), 64'(beat == 0));
        chk("frame_end", 64'(bus.frame_end), 64'(beat == n - 1));
        beat++;
      end
      prev_rd = exp_rd;
      exp_done = (iss == n) && (k == last_k + 2);
      chk("done", 64'(bus.done), 64'(exp_done));
      chk("busy", 64'(bus.busy), 64'(!((iss == n) && (k >= last_k + 2))));
      if (exp_done) begin
        finished = 1'b1;
        done_k = k;
      end
    end
    if (!finished) chk("frame_timeout", 64'(0), 64'(1));
    chk("beat_count", 64'(beat), 64'(exp_n));
    if (exp_done_k >= 0) chk("done_cycle", 64'(done_k), 64'(exp_done_k));
    $display("frame h=%0d w=%0d base=%04h mode=%0d beats=%0d done_at=T+%0d",
             h, w, base, mode, beat, done_k);
  endtask

  typedef struct {
    int          h;
    int          w;
    logic [15:0] base;
    int          mode;
    int          start_k;
    int          exp_n;
    int          exp_done_k;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int beats;
    bit hit;
    vecs[0] = '{3, 4, 16'h0010, 0, 0, 12, 14};
    vecs[1] = '{3, 4, 16'h0010, 2, 0, 12, 16};
    vecs[2] = '{1, 1, 16'h0100, 0, 0, 1, 3};
    vecs[3] = '{3, 0, 16'h0200, 0, 0, 0, 1};
    vecs[4] = '{4, 4, 16'h0300, 0, 3, 16, 18};
    vecs[5] = '{2, 2, 16'hFFFE, 0, 0, 4, 6};
    vecs[6] = '{300, 2, 16'h1000, 0, 0, 448, 450};
    vecs[7] = '{0, 5, 16'h0400, 0, 0, 0, 1};

    reset = 1'b1;
    bus.frame_h = '0; bus.frame_w = '0; bus.base_addr = '0;
    bus.start = 1'b0; bus.hold = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_zero("reset");
    reset = 1'b0;
    @(negedge clk); #1;
    check_zero("idle");

    foreach (vecs[i])
      run_frame(vecs[i].h, vecs[i].w, vecs[i].base, vecs[i].mode,
                vecs[i].start_k, vecs[i].exp_n, vecs[i].exp_done_k);

    for (int i = 0; i < 20; i++) begin
      int rh, rw;
      rh = $urandom_range(0, 6);
      rw = $urandom_range(0, 6);
      run_frame(rh, rw, 16'($urandom), 1, 0, rh * rw, -1);
    end

    // Reset on beat 6 of a 4x4 frame truncates the stream
    bus.frame_h = 9'd4; bus.frame_w = 9'd4; bus.base_addr = 16'h0040;
    bus.start = 1'b1; bus.hold = 1'b0;
    @(posedge clk);
    beats = 0; hit = 1'b0;
    for (int k = 0; k < 100 && !hit; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      if (bus.dout_vld) begin
        if (beats == 6) hit = 1'b1;
        else beats++;
      end
    end
    chk("reach_beat6", 64'(hit), 64'(1));
    reset = 1'b1;
    #1;
    check_zero("midreset");
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      chk("post_reset_done", 64'(bus.done), 64'(0));
      chk("post_reset_vld", 64'(bus.dout_vld), 64'(0));
      chk("post_reset_end", 64'(bus.frame_end), 64'(0));
    end
    $display("reset mid-frame after %0d beats", beats);
    run_frame(4, 4, 16'h0040, 0, 0, 16, 18);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
